enc_src_scheduler: RTL and testbench

// - Round-robin scheduler that shares one encoder input port among SRC_NUM message sources.
// - Grants one source per codeword, held for exactly MES_BEATS accepted beats; never switches mid-codeword.
// - Drives the encoder's gen_valid/gen_data and honours the encoder controller's con_stall back-pressure.
// - Delays the granted source id by ENC_LAT so downstream logic can tag enc_data per codeword.

---
 rtl/enc_pkg.sv | 22 ++
 rtl/enc_rr_picker.sv | 27 ++
 rtl/enc_src_scheduler.sv | 126 ++++++++++++
 tb/tb_enc_src_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared encoder constants and scheduler types for the encoder input-port scheduler.
package enc_pkg;

  localparam int unsigned EGF_DIM       = 4;
  localparam int unsigned ENC_SYM       = 2;
  localparam int unsigned RSC_MES_LEN   = 8;
  localparam int unsigned DATA_W        = ENC_SYM * EGF_DIM;
  localparam int unsigned MES_BEATS_DEF = RSC_MES_LEN / ENC_SYM;
  localparam int unsigned SRC_NUM_DEF   = 4;
  localparam int unsigned SID_W_DEF     = $clog2(SRC_NUM_DEF);

  typedef enum logic {
    SCH_IDLE,
    SCH_BUSY
  } sch_phase_e;

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enc_rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping.
module enc_rr_picker #(
  parameter int unsigned SRC_NUM = 4,
  parameter int unsigned SID_W   = $clog2(SRC_NUM)
) (
  input  logic [SRC_NUM-1:0] req,
  input  logic [SID_W-1:0]   ptr,
  output logic [SID_W-1:0]   idx,
  output logic               any
);

  logic [SID_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < SRC_NUM; i++) begin
      cand = SID_W'((32'(ptr) + i) % SRC_NUM);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/enc_src_scheduler.sv
// Round-robin scheduler sharing one encoder input port among SRC_NUM sources, one codeword per grant.
module enc_src_scheduler
  import enc_pkg::*;
#(
  parameter int unsigned SRC_NUM   = SRC_NUM_DEF,
  parameter int unsigned MES_BEATS = MES_BEATS_DEF,
  parameter int unsigned ENC_LAT   = 2,
  parameter int unsigned SID_W     = $clog2(SRC_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SRC_NUM-1:0]             src_valid,
  input  logic [SRC_NUM-1:0]             src_last,
  input  logic [SRC_NUM-1:0][DATA_W-1:0] src_data,
  output logic [SRC_NUM-1:0]             src_ready,
  input  logic                           con_stall,
  output logic                           gen_valid,
  output logic [DATA_W-1:0]              gen_data,
  output logic [SID_W-1:0]               enc_sid,
  output logic                           enc_sid_vld,
  output logic                           frm_err
);

  localparam int unsigned CNT_W = cnt_width(MES_BEATS);

  sch_phase_e          state_q, state_d;
  logic [SID_W-1:0]    grant_q, grant_d;
  logic [SID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [SID_W-1:0]    pick_idx;
  logic                pick_any;
  logic [SRC_NUM-1:0]  grant_oh;
  logic                last_beat;

  enc_rr_picker #(
    .SRC_NUM (SRC_NUM),
    .SID_W   (SID_W)
  ) u_picker (
    .req (src_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign last_beat = (beat_cnt_q == CNT_W'(MES_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCH_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Grant is only sampled in IDLE, so a codeword can never be split across sources.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      SCH_IDLE: begin
        if (pick_any) begin
          state_d = SCH_BUSY;
          grant_d = pick_idx;
        end
      end
      SCH_BUSY: begin
        if (gen_valid) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_q == SID_W'(SRC_NUM - 1)) ? '0 : grant_q + SID_W'(1);
            state_d    = SCH_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
    gen_valid         = (state_q == SCH_BUSY) && src_valid[grant_q] && !con_stall;
    src_ready         = ((state_q == SCH_BUSY) && !con_stall) ? grant_oh : '0;
    gen_data          = gen_valid ? src_data[grant_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err <= 1'b0;
    end else if (gen_valid && (src_last[grant_q] != last_beat)) begin
      frm_err <= 1'b1;
    end
  end

  // The id pipe free-runs so enc_sid tracks the encoder's fixed latency, not its stalls.
  if (ENC_LAT == 0) begin : g_sid_bypass
    assign enc_sid_vld = gen_valid;
    assign enc_sid     = grant_q;
  end else begin : g_sid_pipe
    logic [ENC_LAT-1:0][SID_W:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= {gen_valid, grant_q};
        for (int unsigned i = 1; i < ENC_LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign {enc_sid_vld, enc_sid} = pipe_q[ENC_LAT-1];
  end

endmodule

// File: tb/tb_enc_src_scheduler.sv
// Bench for enc_src_scheduler: vector table, hand-written corner sequences and a randomized reference model.
module tb_enc_src_scheduler;
  import enc_pkg::*;

  localparam int N   = 4;
  localparam int MB  = 4;
  localparam int LAT = 2;
  localparam int DW  = DATA_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           src_valid;
  logic [N-1:0]           src_last;
  logic [N-1:0][DW-1:0]   src_data;
  logic [N-1:0]           src_ready;
  logic                   con_stall;
  logic                   gen_valid;
  logic [DW-1:0]          gen_data;
  logic [1:0]             enc_sid;
  logic                   enc_sid_vld;
  logic                   frm_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enc_src_scheduler #(
    .SRC_NUM   (N),
    .MES_BEATS (MB),
    .ENC_LAT   (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_last    (src_last),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .con_stall   (con_stall),
    .gen_valid   (gen_valid),
    .gen_data    (gen_data),
    .enc_sid     (enc_sid),
    .enc_sid_vld (enc_sid_vld),
    .frm_err     (frm_err)
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       s;
    logic       gv;
    logic [3:0] rdy;
    int         g;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: spec-level view of the arbiter.
  bit   m_busy;
  int   m_g, m_ptr, m_cnt;
  bit   m_err;
  int   sidq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic s, input logic gv,
                     input logic [3:0] rdy, input int g, input logic err);
    vec_t e;
    e.v = v; e.l = l; e.s = s; e.gv = gv; e.rdy = rdy; e.g = g; e.err = err;
    tbl.push_back(e);
  endtask

  task automatic codeword(input logic [3:0] v, input int g);
    logic [3:0] oh;
    oh = 4'(1 << g);
    add(v, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0);
    for (int k = 0; k < MB - 1; k++) add(v, 4'b0000, 1'b0, 1'b1, oh, g, 1'b0);
    add(v, v, 1'b0, 1'b1, oh, g, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0; src_last = '0; src_data = '0; con_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    sidq = {};
    for (int k = 0; k < LAT; k++) sidq.push_back(0);
  endtask

  function automatic int first_from(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Compare DUT against the model for the current cycle, then advance the model past the edge.
  task automatic model_cycle(input string tag);
    bit          egv;
    logic [N-1:0] erdy;
    logic [DW-1:0] edata;
    int          front, c;
    egv   = m_busy && src_valid[m_g] && !con_stall;
    erdy  = (m_busy && !con_stall) ? N'(1 << m_g) : '0;
    edata = egv ? src_data[m_g] : '0;
    front = sidq[0];
    chk({tag, ".gen_valid"}, 32'(gen_valid), 32'(egv));
    chk({tag, ".src_ready"}, 32'(src_ready), 32'(erdy));
    chk({tag, ".gen_data"},  32'(gen_data),  32'(edata));
    chk({tag, ".frm_err"},   32'(frm_err),   32'(m_err));
    chk({tag, ".sid_vld"},   32'(enc_sid_vld), 32'((front >> 4) & 1));
    if (((front >> 4) & 1) == 1) chk({tag, ".enc_sid"}, 32'(enc_sid), 32'(front & 15));
    void'(sidq.pop_front());
    sidq.push_back((int'(egv) << 4) | m_g);
    if (!m_busy) begin
      c = first_from(m_ptr, src_valid);
      if (c >= 0) begin
        m_busy = 1;
        m_g = c;
      end
    end else if (egv) begin
      if (src_last[m_g] != (m_cnt == MB - 1)) m_err = 1;
      m_cnt++;
      if (m_cnt == MB) begin
        m_cnt = 0;
        m_ptr = (m_g + 1) % N;
        m_busy = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and idle hold with no requests.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      #2;
      chk($sformatf("idle%0d.gen_valid", c), 32'(gen_valid), 32'd0);
      chk($sformatf("idle%0d.src_ready", c), 32'(src_ready), 32'd0);
      chk($sformatf("idle%0d.sid_vld", c), 32'(enc_sid_vld), 32'd0);
      chk($sformatf("idle%0d.frm_err", c), 32'(frm_err), 32'd0);
      tick();
    end

    // Alternation 0,2,0,2; stall mid-codeword on source 1; early src_last on source 0.
    codeword(4'b0101, 0); codeword(4'b0101, 2);
    codeword(4'b0101, 0); codeword(4'b0101, 2);
    add(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0);
    add(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1, 1'b0);
    add(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1, 1'b0);
    for (int k = 0; k < 3; k++) add(4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1, 1'b0);
    add(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1, 1'b0);
    add(4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010, 1, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 0, 1'b0);
    add(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 0, 1'b1);
    add(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1);
    add(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b1);
    add(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 0, 1'b1);

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      logic [DW-1:0] edata;
      src_valid = tbl[r].v;
      src_last  = tbl[r].l;
      con_stall = tbl[r].s;
      for (int i = 0; i < N; i++) src_data[i] = DW'((r << 2) | i);
      edata = tbl[r].gv ? DW'((r << 2) | tbl[r].g) : '0;
      #2;
      chk($sformatf("tbl%0d.gen_valid", r), 32'(gen_valid), 32'(tbl[r].gv));
      chk($sformatf("tbl%0d.src_ready", r), 32'(src_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d.gen_data", r),  32'(gen_data),  32'(edata));
      chk($sformatf("tbl%0d.frm_err", r),   32'(frm_err),   32'(tbl[r].err));
      tick();
    end

    // Async reset in the middle of source 3's codeword.
    do_reset();
    src_valid = 4'b1000;
    src_last  = 4'b0000;
    for (int i = 0; i < N; i++) src_data[i] = DW'(8'hA0 | i);
    #2; chk("rst.idle.gen_valid", 32'(gen_valid), 32'd0); tick();
    #2; chk("rst.b1.gen_valid", 32'(gen_valid), 32'd1);
        chk("rst.b1.gen_data", 32'(gen_data), 32'hA3); tick();
    #2; chk("rst.b2.src_ready", 32'(src_ready), 32'b1000); tick();
    #2; chk("rst.pipe.sid_vld", 32'(enc_sid_vld), 32'd1);
        chk("rst.pipe.enc_sid", 32'(enc_sid), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst.async.gen_valid", 32'(gen_valid), 32'd0);
    chk("rst.async.src_ready", 32'(src_ready), 32'd0);
    chk("rst.async.gen_data", 32'(gen_data), 32'd0);
    chk("rst.async.sid_vld", 32'(enc_sid_vld), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_valid = 4'b1001;
    #2; chk("rst.after.idle", 32'(gen_valid), 32'd0); tick();
    #2; chk("rst.after.src_ready", 32'(src_ready), 32'b0001);
        chk("rst.after.gen_data", 32'(gen_data), 32'hA0);
    tick();

    // Randomized traffic against the reference model, reset between segments.
    for (int seg = 0; seg < 5; seg++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        src_valid = N'($urandom_range(0, 15));
        for (int i = 0; i < N; i++) begin
          src_last[i] = ($urandom_range(0, 3) == 0);
          src_data[i] = DW'($urandom);
        end
        con_stall = ($urandom_range(0, 3) == 0);
        #2;
        model_cycle($sformatf("rnd%0d.%0d", seg, c));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
